// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Processor-side interrupt responder. Takes a pending vectored
//               interrupt at an instruction boundary, stalls the core while it
//               saves PC/flags and jumps to the ISR vector, then restores PC and
//               flags on return-from-interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
    parameter int AW = 8,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_pending,
    input  logic [AW-1:0] vector,
    input  logic          boundary,
    input  logic [AW-1:0] pc_in,
    input  logic [FW-1:0] flags_in,
    input  logic          reti,
    input  logic          ei,
    input  logic          di,
    output logic          irq_enable,
    output logic          i_clr,
    output logic          stall,
    output logic          pc_load,
    output logic [AW-1:0] pc_out,
    output logic          flags_load,
    output logic [FW-1:0] flags_out,
    output logic          in_isr
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_SAVE    = 3'd1,
        S_VECTOR  = 3'd2,
        S_ISR     = 3'd3,
        S_RESTORE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          gie_q, gie_d;
    logic [AW-1:0] saved_pc_q, saved_pc_d;
    logic [FW-1:0] saved_flags_q, saved_flags_d;
    logic [AW-1:0] vec_lat_q, vec_lat_d;
    logic          take;

    // State and context registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= S_RUN;
            gie_q         <= 1'b0;
            saved_pc_q    <= '0;
            saved_flags_q <= '0;
            vec_lat_q     <= '0;
        end else begin
            state_q       <= state_d;
            gie_q         <= gie_d;
            saved_pc_q    <= saved_pc_d;
            saved_flags_q <= saved_flags_d;
            vec_lat_q     <= vec_lat_d;
        end
    end

    // Next state, context capture and outputs; outputs depend on registers only.
    always_comb begin
        state_d       = state_q;
        saved_pc_d    = saved_pc_q;
        saved_flags_d = saved_flags_q;
        vec_lat_d     = vec_lat_q;
        i_clr         = 1'b0;
        stall         = 1'b0;
        pc_load       = 1'b0;
        pc_out        = '0;
        flags_load    = 1'b0;
        flags_out     = '0;
        in_isr        = 1'b0;

        // A di in the same cycle as the boundary vetoes entry.
        take = (state_q == S_RUN) && boundary && i_pending && gie_q && !di;

        // di dominates ei; ei during the ISR only becomes visible back in RUN
        // because irq_enable is gated by the RUN state.
        if (di) begin
            gie_d = 1'b0;
        end else if (ei) begin
            gie_d = 1'b1;
        end else begin
            gie_d = gie_q;
        end

        // Controller encoder is held off outside RUN, so there is no nesting.
        irq_enable = gie_q && (state_q == S_RUN);

        case (state_q)
            S_RUN: begin
                if (take) begin
                    saved_pc_d    = pc_in;
                    saved_flags_d = flags_in;
                    vec_lat_d     = vector;
                    state_d       = S_SAVE;
                end
            end
            S_SAVE: begin
                stall   = 1'b1;
                state_d = S_VECTOR;
            end
            S_VECTOR: begin
                // Latched vector is used; the controller may have moved on.
                stall   = 1'b1;
                pc_load = 1'b1;
                pc_out  = vec_lat_q;
                i_clr   = 1'b1;
                state_d = S_ISR;
            end
            S_ISR: begin
                in_isr = 1'b1;
                if (reti) begin
                    state_d = S_RESTORE;
                end
            end
            S_RESTORE: begin
                stall      = 1'b1;
                pc_load    = 1'b1;
                pc_out     = saved_pc_q;
                flags_load = 1'b1;
                flags_out  = saved_flags_q;
                in_isr     = 1'b1;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Self-checking bench for irq_sequencer: directed vector table,
//               hand-written reset-abort sequence and randomized stimulus
//               against an event-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

    localparam int AW = 8;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          i_pending;
    logic [AW-1:0] vector;
    logic          boundary;
    logic [AW-1:0] pc_in;
    logic [FW-1:0] flags_in;
    logic          reti;
    logic          ei;
    logic          di;
    logic          irq_enable;
    logic          i_clr;
    logic          stall;
    logic          pc_load;
    logic [AW-1:0] pc_out;
    logic          flags_load;
    logic [FW-1:0] flags_out;
    logic          in_isr;

    int total = 0;
    int bad   = 0;

    // {irq_enable, i_clr, stall, pc_load, pc_out, flags_load, flags_out, in_isr}
    typedef logic [17:0] ovec_t;

    irq_sequencer #(.AW(AW), .FW(FW)) dut (
        .clk        (clk),
        .clr        (clr),
        .i_pending  (i_pending),
        .vector     (vector),
        .boundary   (boundary),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .reti       (reti),
        .ei         (ei),
        .di         (di),
        .irq_enable (irq_enable),
        .i_clr      (i_clr),
        .stall      (stall),
        .pc_load    (pc_load),
        .pc_out     (pc_out),
        .flags_load (flags_load),
        .flags_out  (flags_out),
        .in_isr     (in_isr)
    );

    always #5 clk = ~clk;

    wire ovec_t dut_o = {irq_enable, i_clr, stall, pc_load, pc_out,
                         flags_load, flags_out, in_isr};

    function automatic ovec_t mk(input logic ie, input logic ic, input logic st,
                                 input logic pl, input logic [7:0] pco,
                                 input logic fl, input logic [3:0] flo,
                                 input logic isr);
        return {ie, ic, st, pl, pco, fl, flo, isr};
    endfunction

    // ---------------- reference model: scheduled output events ----------------
    // A taken interrupt schedules two fixed stall cycles, then the core sits in
    // the handler until reti schedules one restore cycle.
    bit            gie_m;
    bit            isr_m;
    ovec_t         sched[$];
    logic [AW-1:0] spc_m;
    logic [FW-1:0] sfl_m;

    task automatic model_reset();
        gie_m = 1'b0;
        isr_m = 1'b0;
        sched.delete();
        spc_m = '0;
        sfl_m = '0;
    endtask

    function automatic ovec_t model_out();
        if (sched.size() > 0) return sched[0];
        if (isr_m)            return mk(0, 0, 0, 0, 8'd0, 0, 4'd0, 1);
        return mk(gie_m, 0, 0, 0, 8'd0, 0, 4'd0, 0);
    endfunction

    task automatic model_edge();
        bit running;
        bit handling;
        running  = (sched.size() == 0) && !isr_m;
        handling = (sched.size() == 0) && isr_m;
        if (sched.size() > 0) void'(sched.pop_front());
        if (running && boundary && i_pending && gie_m && !di) begin
            spc_m = pc_in;
            sfl_m = flags_in;
            sched.push_back(mk(0, 0, 1, 0, 8'd0, 0, 4'd0, 0));
            sched.push_back(mk(0, 1, 1, 1, vector, 0, 4'd0, 0));
            isr_m = 1'b1;
        end
        if (handling && reti) begin
            isr_m = 1'b0;
            sched.push_back(mk(0, 0, 1, 1, spc_m, 1, sfl_m, 1));
        end
        if (di)      gie_m = 1'b0;
        else if (ei) gie_m = 1'b1;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input ovec_t exp);
        total++;
        if (dut_o !== exp) begin
            bad++;
            $display("FAIL %s: got %h (ie,iclr,stall,pcl,pc,fl,flo,isr) required %h",
                     name, dut_o, exp);
        end
    endtask

    task automatic drive(input logic pend, input logic [7:0] vec, input logic bnd,
                         input logic [7:0] pc, input logic [3:0] flg,
                         input logic rt, input logic e, input logic d);
        i_pending = pend;
        vector    = vec;
        boundary  = bnd;
        pc_in     = pc;
        flags_in  = flg;
        reti      = rt;
        ei        = e;
        di        = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       pend;
        logic [7:0] vec;
        logic       bnd;
        logic [7:0] pc;
        logic [3:0] flg;
        logic       rt;
        logic       e;
        logic       d;
        ovec_t      exp;
    } row_t;

    function automatic row_t row(input logic pend, input logic [7:0] vec,
                                 input logic bnd, input logic [7:0] pc,
                                 input logic [3:0] flg, input logic rt,
                                 input logic e, input logic d, input ovec_t exp);
        row_t r;
        r.pend = pend; r.vec = vec; r.bnd = bnd; r.pc = pc; r.flg = flg;
        r.rt = rt; r.e = e; r.d = d; r.exp = exp;
        return r;
    endfunction

    row_t tbl[22];

    initial begin
        ovec_t run_on, run_off, save, isr;
        run_on  = mk(1, 0, 0, 0, 8'd0, 0, 4'd0, 0);
        run_off = mk(0, 0, 0, 0, 8'd0, 0, 4'd0, 0);
        save    = mk(0, 0, 1, 0, 8'd0, 0, 4'd0, 0);
        isr     = mk(0, 0, 0, 0, 8'd0, 0, 4'd0, 1);

        //             pend vec  bnd pc  flg     rt e  d   expected after edge
        tbl[0]  = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 1, 0, run_on);
        tbl[1]  = row(1, 8'd230, 1, 8'd17, 4'b0010, 0, 0, 0, save);
        tbl[2]  = row(0, 8'd200, 0, 8'd0,  4'd0, 0, 0, 0, mk(0, 1, 1, 1, 8'd230, 0, 4'd0, 0));
        tbl[3]  = row(0, 8'd200, 0, 8'd0,  4'd0, 0, 0, 0, isr);
        tbl[4]  = row(1, 8'd50,  1, 8'd99, 4'd7, 0, 0, 0, isr);
        tbl[5]  = row(0, 8'd0,   0, 8'd0,  4'd0, 1, 0, 0, mk(0, 0, 1, 1, 8'd17, 1, 4'b0010, 1));
        tbl[6]  = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 0, run_on);
        tbl[7]  = row(1, 8'd60,  1, 8'd50, 4'd3, 0, 0, 1, run_off);
        tbl[8]  = row(1, 8'd60,  1, 8'd51, 4'd3, 0, 0, 0, run_off);
        tbl[9]  = row(0, 8'd0,   0, 8'd0,  4'd0, 1, 1, 1, run_off);
        tbl[10] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 1, 0, run_on);
        tbl[11] = row(1, 8'd9,   1, 8'd33, 4'd5, 0, 0, 0, save);
        tbl[12] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 0, mk(0, 1, 1, 1, 8'd9, 0, 4'd0, 0));
        tbl[13] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 1, isr);
        tbl[14] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 1, 0, isr);
        tbl[15] = row(0, 8'd0,   0, 8'd0,  4'd0, 1, 0, 0, mk(0, 0, 1, 1, 8'd33, 1, 4'd5, 1));
        tbl[16] = row(1, 8'd100, 1, 8'd40, 4'd1, 0, 0, 0, run_on);
        tbl[17] = row(1, 8'd100, 1, 8'd40, 4'd1, 0, 0, 0, save);
        tbl[18] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 0, mk(0, 1, 1, 1, 8'd100, 0, 4'd0, 0));
        tbl[19] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 0, isr);
        tbl[20] = row(0, 8'd0,   0, 8'd0,  4'd0, 1, 0, 0, mk(0, 0, 1, 1, 8'd40, 1, 4'd1, 1));
        tbl[21] = row(0, 8'd0,   0, 8'd0,  4'd0, 0, 0, 0, run_on);

        // reset
        clr = 1'b1;
        drive(0, 8'd0, 0, 8'd0, 4'd0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", run_off);
        clr = 1'b0;

        // directed table
        foreach (tbl[i]) begin
            drive(tbl[i].pend, tbl[i].vec, tbl[i].bnd, tbl[i].pc, tbl[i].flg,
                  tbl[i].rt, tbl[i].e, tbl[i].d);
            step();
            check($sformatf("table_row%0d", i), tbl[i].exp);
        end

        // reset asserted in SAVE aborts the entry sequence
        drive(1, 8'd77, 1, 8'd12, 4'd9, 0, 0, 0);
        step();
        check("abort_save", save);
        drive(1, 8'd77, 0, 8'd0, 4'd0, 0, 0, 0);
        clr = 1'b1;
        #1;
        model_reset();
        check("abort_async_zero", run_off);
        step();
        check("abort_held", run_off);
        clr = 1'b0;
        step();
        check("abort_no_iclr", run_off);
        step();
        check("abort_gie_off", run_off);

        // randomized stimulus against the reference model
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
                  8'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 11) == 0));
            step();
            check($sformatf("random_cycle%0d", n), model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_sequencer.md
# irq_sequencer

Processor-side responder for the maskable vectored interrupt controller. It samples the controller's pending flag and ISR vector at instruction boundaries, then stalls the core. It saves the return PC and ALU flags, loads the vector into the PC, and pulses the controller's pending-clear. On return-from-interrupt it restores PC and flags. It sits between the interrupt controller and the PC/flag registers of the datapath, and drives the controller's enable input.

## Interface
- AW, 8, PC / vector address width
- FW, 4, ALU flag width
- clk  in  1  system clock, all state updates on rising edge
- clr  in  1  asynchronous, active-high reset
- i_pending  in  1  interrupt pending from controller
- vector  in  AW  ISR address from controller
- boundary  in  1  one-cycle strobe: current instruction retired, pc_in valid
- pc_in  in  AW  address of next instruction to execute
- flags_in  in  FW  current ALU flags
- reti  in  1  return-from-interrupt decoded (one-cycle strobe)
- ei  in  1  enable-interrupts instruction strobe
- di  in  1  disable-interrupts instruction strobe
- irq_enable  out  1  drives controller enable
- i_clr  out  1  drives controller pending-clear
- stall  out  1  holds fetch/decode
- pc_load  out  1  load pc_out into PC this cycle
- pc_out  out  AW  PC load value
- flags_load  out  1  load flags_out into flag register this cycle
- flags_out  out  FW  flag restore value
- in_isr  out  1  servicing an interrupt

## Operation
- States: RUN, SAVE, VECTOR, ISR, RESTORE.
- Internal registers: gie (global interrupt enable), saved_pc[AW], saved_flags[FW], vec_lat[AW].
- irq_enable = gie && state==RUN.
  - This is combinational from registers.
  - The controller's encoder is disabled outside RUN, so there is no nesting.
- take = state==RUN && boundary && i_pending && gie && !di.
- RUN:
  - On take: saved_pc<=pc_in, saved_flags<=flags_in, vec_lat<=vector; go to SAVE.
  - Otherwise stay in RUN.
- SAVE: stall=1; go to VECTOR unconditionally.
- VECTOR:
  - stall=1, pc_load=1, pc_out=vec_lat, i_clr=1 (one cycle).
  - Go to ISR.
- ISR:
  - in_isr=1.
  - On reti: go to RESTORE.
  - boundary is ignored in this state.
- RESTORE:
  - stall=1, pc_load=1, pc_out=saved_pc, flags_load=1, flags_out=saved_flags, in_isr=1.
  - Go to RUN.
- gie update, in any state:
  - di clears gie; ei sets gie.
  - di wins if both are asserted.
  - ei in ISR sets gie but takes effect only on return to RUN.
- The i_clr pulse clears all controller pending bits, including lower-priority ones latched at the same time. This is accepted behaviour.
- reti outside ISR is ignored: no pc_load and no state change.
- i_pending or vector changing after take does not matter; vec_lat is used.
- In states other than those listed above, all strobes (pc_load, flags_load, i_clr, stall) are 0 and pc_out/flags_out are 0.

## Timing
- Reset (async, clr=1):
  - state=RUN, gie=0, saved_pc=0, saved_flags=0, vec_lat=0.
  - All outputs 0, including irq_enable.
- Reset mid-sequence aborts immediately: no pc_load and no i_clr are emitted after clr rises.
- Interrupt entry latency:
  - take sampled at edge ending cycle N.
  - SAVE in cycle N+1.
  - VECTOR (pc_load, i_clr) in cycle N+2.
  - ISR from cycle N+3.
- Exit latency:
  - reti sampled at edge ending cycle M.
  - RESTORE (pc_load, flags_load) in cycle M+1.
  - RUN from M+2.
  - irq_enable=1 in M+2 if gie.
- stall is high for exactly 2 cycles on entry and 1 cycle on exit.
- i_clr, pc_load and flags_load are single-cycle pulses and are never asserted in consecutive cycles.
- Back-to-back: i_pending high at the first boundary in RUN after RESTORE is taken normally, with minimum 1 RUN cycle.

## Test plan
- Reset, then ei, i_pending=1, vector=230, boundary with pc_in=17, flags_in=4'b0010 -> stall for 2 cycles; cycle N+2 pc_load=1, pc_out=230, i_clr=1; in_isr=1 from N+3; irq_enable=0.
- In ISR, reti -> next cycle pc_load=1, pc_out=17, flags_load=1, flags_out=4'b0010; RUN after that; irq_enable=1.
- gie=0 (after reset, no ei), i_pending=1, boundary -> no stall, no pc_load, irq_enable=0. Then di and boundary with pending in the same cycle while gie=1 -> not taken; gie=0 afterwards.
- reti in RUN, and ei+di in the same cycle -> no pc_load; gie=0.
- clr asserted in SAVE -> outputs 0 immediately; no i_clr pulse; state RUN, gie=0.
- i_pending drops and vector changes to 200 during SAVE -> VECTOR still loads 230.
